data_mem_responder: RTL
=======================

# data_mem_responder

Responder side of the data-memory port driven by the pipeline's memory-access stage. It serves word reads and writes from a synchronous on-chip BRAM and decodes a small MMIO window holding a UART receive FIFO and a one-entry transmit holding register. It raises `stall` whenever an MMIO access cannot complete in the current cycle. It sits between the core's memory stage and the UART rx/tx blocks.

## Interface
Parameters:
- `DEPTH_WORDS`, 16384: BRAM size in 32-bit words; power of two.
- `RX_FIFO_DEPTH`, 16: UART receive FIFO entries; power of two, at least 2.
- `MMIO_BASE`, 32'hFFFF_FF00: base of the 16-byte MMIO window.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `re`  in  1  load request from the memory stage.
- `we`  in  1  store request from the memory stage.
- `data_addr`  in  32  byte address; bits [1:0] ignored.
- `din`  in  32  store data.
- `dout`  out  32  load data, registered.
- `stall`  out  1  combinational; request not accepted this cycle.
- `rx_data`  in  8  byte from the UART receiver.
- `rx_valid`  in  1  one-cycle push strobe for `rx_data`.
- `tx_data`  out  8  byte to the UART transmitter.
- `tx_valid`  out  1  `tx_data` is valid.
- `tx_ready`  in  1  the transmitter accepts the byte when `tx_valid && tx_ready`.

## Operation
Address decode. A request hits MMIO when `data_addr[31:4] == MMIO_BASE[31:4]`. Every other address goes to BRAM at word index `data_addr[$clog2(DEPTH_WORDS)+1:2]`. Higher address bits alias.

MMIO map (offsets):
- 0x0, RX data. Read pops the FIFO head and returns it in `dout[7:0]` with upper bits 0. Write is ignored.
- 0x4, RX status. Read returns bit0 = FIFO non-empty and bit1 = overflow (sticky); other bits 0. A read of this register clears overflow.
- 0x8, TX data. Write loads `din[7:0]` into the holding register and sets `tx_valid`. Read returns 0.
- 0xC, TX status. Read returns bit0 = holding register free (`!tx_valid`).

Stall rules:
- `stall = re && hit(0x0) && fifo_empty`, or
- `stall = we && hit(0x8) && tx_valid && !tx_ready`.
- While stalled there is no pop, no load and no BRAM write. The core holds the request stable and it retries every cycle.

Other request rules:
- `re && we` together is illegal. The store takes priority and `dout` is undefined.
- No request: `dout` holds its previous value.

RX FIFO:
- `rx_valid` pushes unless the FIFO is full. A full FIFO drops the byte and sets overflow.
- Push and pop in the same cycle:
  - FIFO full: both occur and the count is unchanged.
  - FIFO empty: the pop stalls this cycle and succeeds the next cycle.
- Read/write pointers wrap modulo `RX_FIFO_DEPTH`. A count register of width `$clog2(RX_FIFO_DEPTH)+1` distinguishes full from empty.

TX holding register: `tx_valid` clears on `tx_valid && tx_ready`. A TX write in that same cycle reloads the register, so `tx_valid` stays 1 with the new byte.

## Timing
- Read latency is 1. A request accepted at edge N drives `dout` after edge N, for BRAM and MMIO alike. The next pipeline register captures it.
- A store is visible to a load accepted at the following edge. There is no read-during-write hazard on the same edge, because requests are serialized one per cycle.
- `stall` depends combinationally on request inputs and current state only, never on `rx_valid` of the same cycle.
- Reset values: `dout`=0, `tx_valid`=0, `tx_data`=0, FIFO empty, overflow=0. BRAM contents are not reset.
- `rst` asserted mid-operation discards FIFO contents and any pending TX byte at that edge.

## Configuration
- `DMEM_MMIO_UART_EN` defined: MMIO decode, RX FIFO and TX register are present as described above.
- Undefined:
  - All addresses go to BRAM, including the MMIO window.
  - `stall` is tied 0, `tx_valid`/`tx_data` are tied 0, and `rx_*` are ignored.
  - No FIFO or TX logic is instantiated.

## Test plan
- Store 32'hDEADBEEF to 0x100, then load 0x100 the next cycle: `dout`=32'hDEADBEEF one cycle after the load is accepted, `stall` stays 0.
- Load RX data with the FIFO empty, then push 8'h5A on `rx_valid`: `stall`=1 until the push is registered, then `dout`=32'h0000005A and the FIFO is empty again.
- Push 17 bytes with depth 16, then read RX status: `dout`=32'h3 (non-empty, overflow); a second status read returns 32'h1.
- Write TX 8'h41 with `tx_ready`=0, then write TX 8'h42: the second write stalls until `tx_ready`=1. In that cycle 8'h41 is sent, 8'h42 loads, and `tx_valid` stays 1.
- Assert `rst` with 3 FIFO entries and `tx_valid`=1: the next cycle shows RX status 0, `tx_valid`=0 and `dout`=0.
- Build without `DMEM_MMIO_UART_EN`: store/load at MMIO_BASE+0x8 round-trips 32'h12345678 and `stall` is never 1.

Source files
------------

// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Responder for the core's data-memory port. Word loads/stores are served
//   from a synchronous on-chip BRAM. A 16-byte MMIO window holds a UART
//   receive FIFO and a one-entry transmit holding register.
//
//   Build option: DMEM_MMIO_UART_EN
//     defined   -> MMIO decode, RX FIFO and TX register present
//     undefined -> every address goes to BRAM, stall/tx_* tied 0, rx_* ignored
//
// Ports
//   clk, rst         clock (rising edge), synchronous active-high reset
//   re, we           load / store request from the memory stage
//   data_addr, din   byte address (bits [1:0] ignored), store data
//   dout             registered load data (1-cycle latency, holds when idle)
//   stall            combinational: request not accepted this cycle
//   rx_data/rx_valid byte + push strobe from the UART receiver
//   tx_data/tx_valid byte + valid towards the UART transmitter
//   tx_ready         transmitter takes the byte on tx_valid && tx_ready
module data_mem_responder #(
    parameter int unsigned DEPTH_WORDS   = 16384,
    parameter int unsigned RX_FIFO_DEPTH = 16,
    parameter logic [31:0] MMIO_BASE     = 32'hFFFF_FF00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        re,
    input  logic        we,
    input  logic [31:0] data_addr,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic        stall,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);
    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    logic [AW-1:0] word_idx;
    logic          mmio_hit;
    logic [31:0]   mmio_rdata;
    logic          stall_int;
    logic          bram_wr;
    logic          bram_rd;
    logic          mmio_rd;

    assign word_idx = data_addr[AW+1:2];

    // Stores win over loads when both are raised; BRAM requests never stall.
    always_comb begin
        bram_wr = we && !mmio_hit;
        bram_rd = re && !we && !mmio_hit;
        mmio_rd = re && !we && mmio_hit && !stall_int;
    end

    // ---------------------------------------------------------------- BRAM
    logic [31:0] mem [DEPTH_WORDS];
    logic [31:0] bram_rdata_q;

    always_ff @(posedge clk) begin
        if (bram_wr) mem[word_idx] <= din;
    end

    // Output register only loads on an accepted BRAM read, so dout holds
    // across idle cycles.
    always_ff @(posedge clk) begin
        if (rst)          bram_rdata_q <= '0;
        else if (bram_rd) bram_rdata_q <= mem[word_idx];
    end

    // ------------------------------------------------- read-data selection
    logic        src_mmio_q, src_mmio_d;
    logic [31:0] mmio_rdata_q, mmio_rdata_d;

    always_comb begin
        src_mmio_d   = src_mmio_q;
        mmio_rdata_d = mmio_rdata_q;
        if (bram_rd) begin
            src_mmio_d = 1'b0;
        end else if (mmio_rd) begin
            src_mmio_d   = 1'b1;
            mmio_rdata_d = mmio_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            src_mmio_q   <= 1'b0;
            mmio_rdata_q <= '0;
        end else begin
            src_mmio_q   <= src_mmio_d;
            mmio_rdata_q <= mmio_rdata_d;
        end
    end

    assign dout  = src_mmio_q ? mmio_rdata_q : bram_rdata_q;
    assign stall = stall_int;

`ifdef DMEM_MMIO_UART_EN
    localparam int unsigned FW = $clog2(RX_FIFO_DEPTH);
    localparam logic [FW:0] FIFO_FULL = (FW+1)'(RX_FIFO_DEPTH);

    logic [1:0] mmio_off;
    logic       unused_bits;

    assign mmio_hit    = (data_addr[31:4] == MMIO_BASE[31:4]);
    assign mmio_off    = data_addr[3:2];
    assign unused_bits = ^data_addr;

    logic [7:0]  fifo_mem [RX_FIFO_DEPTH];
    logic [FW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [FW:0]   count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          tx_valid_q, tx_valid_d;
    logic [7:0]    tx_data_q, tx_data_d;

    logic fifo_empty, fifo_full;
    logic rx_pop, rx_push, rx_drop, stat_rd, tx_wr;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == FIFO_FULL);

    always_comb begin
        // rx_valid deliberately does not feed stall: an empty-FIFO pop waits
        // one cycle for the push to register.
        stall_int = (re && mmio_hit && (mmio_off == 2'd0) && fifo_empty) ||
                    (we && mmio_hit && (mmio_off == 2'd2) && tx_valid_q && !tx_ready);

        rx_pop  = mmio_rd && (mmio_off == 2'd0);
        stat_rd = mmio_rd && (mmio_off == 2'd1);
        tx_wr   = we && mmio_hit && (mmio_off == 2'd2) && !stall_int;
        // A full FIFO still accepts a push when the head leaves this cycle.
        rx_push = rx_valid && (!fifo_full || rx_pop);
        rx_drop = rx_valid && !rx_push;

        rd_ptr_d   = rx_pop  ? rd_ptr_q + FW'(1) : rd_ptr_q;
        wr_ptr_d   = rx_push ? wr_ptr_q + FW'(1) : wr_ptr_q;
        count_d    = count_q + (FW+1)'(rx_push) - (FW+1)'(rx_pop);
        overflow_d = (overflow_q && !stat_rd) || rx_drop;

        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        if (tx_wr) begin
            tx_valid_d = 1'b1;
            tx_data_d  = din[7:0];
        end else if (tx_valid_q && tx_ready) begin
            tx_valid_d = 1'b0;
        end

        mmio_rdata = '0;
        case (mmio_off)
            2'd0: mmio_rdata = {24'h0, fifo_mem[rd_ptr_q]};
            2'd1: mmio_rdata = {30'h0, overflow_q, !fifo_empty};
            2'd2: mmio_rdata = '0;
            2'd3: mmio_rdata = {31'h0, !tx_valid_q};
            default: mmio_rdata = '0;
        endcase
    end

    // FIFO storage is not reset; the pointers/count define what is live.
    always_ff @(posedge clk) begin
        if (rx_push) fifo_mem[wr_ptr_q] <= rx_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
        end
    end

    assign tx_valid = tx_valid_q;
    assign tx_data  = tx_data_q;
`else
    logic unused_bits;

    assign mmio_hit    = 1'b0;
    assign mmio_rdata  = '0;
    assign stall_int   = 1'b0;
    assign tx_valid    = 1'b0;
    assign tx_data     = '0;
    assign unused_bits = ^{data_addr, rx_data, rx_valid, tx_ready, MMIO_BASE,
                           RX_FIFO_DEPTH[0]};
`endif

endmodule
